// File: rtl/sdram_access_arbiter.sv
// Arbitrates one SDRAM command port between reader (priority) and writer, one burst in flight.
// Grant/cmd one edge after req; cmd held until mem_cmd_ready; requests ignored until burst done.
module sdram_access_arbiter #(
  parameter int ADDR_WIDTH      = 21,
  parameter int WR_STARVE_LIMIT = 4,
  parameter int LOG_LEVEL       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_gnt,
  output logic                  wr_done,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_we,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  input  logic                  mem_done,
  output logic                  busy
);

  localparam int CNT_W = (WR_STARVE_LIMIT < 1) ? 1 : $clog2(WR_STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(WR_STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             owner_wr;
  logic             pick_wr;
  logic             unused_log;

  assign unused_log = (LOG_LEVEL > 0);

  // Writer wins a contested slot only once the reader has used up its allowance.
  assign pick_wr = wr_req && (!rd_req || (starve_cnt == STARVE_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      owner_wr      <= 1'b0;
      rd_gnt        <= 1'b0;
      wr_gnt        <= 1'b0;
      rd_done       <= 1'b0;
      wr_done       <= 1'b0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_we    <= 1'b0;
      mem_cmd_addr  <= '0;
      busy          <= 1'b0;
    end else begin
      rd_gnt  <= 1'b0;
      wr_gnt  <= 1'b0;
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req || wr_req) begin
            owner_wr      <= pick_wr;
            mem_cmd_valid <= 1'b1;
            mem_cmd_we    <= pick_wr;
            mem_cmd_addr  <= pick_wr ? wr_addr : rd_addr;
            rd_gnt        <= !pick_wr;
            wr_gnt        <= pick_wr;
            busy          <= 1'b1;
            state         <= ISSUE;
            if (pick_wr || !wr_req)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ISSUE: begin
          if (mem_cmd_valid && mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            state         <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (mem_done) begin
            rd_done <= !owner_wr;
            wr_done <= owner_wr;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_cmd_valid <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed bench for sdram_access_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_sdram_access_arbiter;

  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req, wr_req, mem_cmd_ready, mem_done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_gnt, rd_done, wr_gnt, wr_done;
  logic          mem_cmd_valid, mem_cmd_we, busy;
  logic [AW-1:0] mem_cmd_addr;

  int n_checks = 0;
  int n_errors = 0;

  sdram_access_arbiter #(
    .ADDR_WIDTH(AW), .WR_STARVE_LIMIT(4), .LOG_LEVEL(2)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_done(mem_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rr, wr;
    logic [AW-1:0] ra, wa;
    logic          rdy, dn;
    logic          e_rg, e_wg, e_rd, e_wd, e_v, e_we;
    logic [AW-1:0] e_a;
    logic          e_busy;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0;
    mem_cmd_ready = 0; mem_done = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    tick();
  endtask

  task automatic wait_gnt(output bit got);
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      tick();
      if (rd_gnt || wr_gnt) got = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            got;
    bit            order_wr [10];
    logic [AW-1:0] stall_addr;

    //        rr wr ra        wa        rdy dn  rg wg rd wd v  we e_a       busy
    vecs[0]  = '{1'b1,1'b0,21'h00100,21'h0,    1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,21'h00100,1'b1};
    vecs[1]  = '{1'b0,1'b0,21'h0,    21'h0,    1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,21'h00100,1'b1};
    vecs[2]  = '{1'b0,1'b0,21'h0,    21'h0,    1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,21'h00100,1'b1};
    vecs[3]  = '{1'b0,1'b0,21'h0,    21'h0,    1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,21'h0,    1'b1};
    vecs[4]  = '{1'b0,1'b0,21'h0,    21'h0,    1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,21'h0,    1'b1};
    vecs[5]  = '{1'b0,1'b0,21'h0,    21'h0,    1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,21'h0,    1'b0};
    vecs[6]  = '{1'b0,1'b0,21'h0,    21'h0,    1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,21'h0,    1'b0};
    vecs[7]  = '{1'b0,1'b1,21'h0,    21'h1F000,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,21'h1F000,1'b1};
    vecs[8]  = '{1'b0,1'b0,21'h0,    21'h0,    1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,21'h0,    1'b1};
    vecs[9]  = '{1'b0,1'b0,21'h0,    21'h0,    1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,21'h0,    1'b0};
    vecs[10] = '{1'b0,1'b0,21'h0,    21'h0,    1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,21'h0,    1'b0};
    vecs[11] = '{1'b1,1'b0,21'h0ABCD,21'h0,    1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,21'h0ABCD,1'b1};
    vecs[12] = '{1'b0,1'b1,21'h0,    21'h00055,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,21'h0ABCD,1'b1};
    vecs[13] = '{1'b0,1'b1,21'h0,    21'h00055,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,21'h0,    1'b1};
    vecs[14] = '{1'b0,1'b1,21'h0,    21'h00055,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,21'h0,    1'b1};
    vecs[15] = '{1'b0,1'b1,21'h0,    21'h00055,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,21'h0,    1'b0};
    vecs[16] = '{1'b0,1'b1,21'h0,    21'h00055,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,21'h00055,1'b1};
    vecs[17] = '{1'b0,1'b0,21'h0,    21'h0,    1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,21'h0,    1'b1};
    vecs[18] = '{1'b0,1'b0,21'h0,    21'h0,    1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,21'h0,    1'b0};
    vecs[19] = '{1'b0,1'b0,21'h0,    21'h0,    1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,21'h0,    1'b0};

    idle_inputs();
    reset = 1;
    #3;
    check("reset_valid", 32'(mem_cmd_valid), 32'd0);
    check("reset_busy",  32'(busy), 32'd0);
    check("reset_pulses", {28'd0, rd_gnt, wr_gnt, rd_done, wr_done}, 32'd0);
    check("reset_addr_we", {10'd0, mem_cmd_we, mem_cmd_addr}, 32'd0);
    tick();
    reset = 0;
    tick();

    for (int i = 0; i < 20; i++) begin
      rd_req = vecs[i].rr; wr_req = vecs[i].wr;
      rd_addr = vecs[i].ra; wr_addr = vecs[i].wa;
      mem_cmd_ready = vecs[i].rdy; mem_done = vecs[i].dn;
      tick();
      check($sformatf("vec%0d_pulses", i), {28'd0, rd_gnt, wr_gnt, rd_done, wr_done},
            {28'd0, vecs[i].e_rg, vecs[i].e_wg, vecs[i].e_rd, vecs[i].e_wd});
      check($sformatf("vec%0d_valid", i), 32'(mem_cmd_valid), 32'(vecs[i].e_v));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_v)
        check($sformatf("vec%0d_cmd", i), {10'd0, mem_cmd_we, mem_cmd_addr},
              {10'd0, vecs[i].e_we, vecs[i].e_a});
    end

    // Contention: reader four times, then writer, repeated.
    do_reset();
    order_wr = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    rd_req = 1; wr_req = 1; rd_addr = 21'h00200; wr_addr = 21'h00300;
    for (int g = 0; g < 10; g++) begin
      wait_gnt(got);
      check($sformatf("starve_gnt%0d_seen", g), 32'(got), 32'd1);
      check($sformatf("starve_gnt%0d_who", g), {30'd0, rd_gnt, wr_gnt},
            order_wr[g] ? 32'd1 : 32'd2);
      mem_cmd_ready = 1;
      tick();
      mem_cmd_ready = 0; mem_done = 1;
      tick();
      mem_done = 0;
      check($sformatf("starve_done%0d", g), {30'd0, rd_done, wr_done},
            order_wr[g] ? 32'd1 : 32'd2);
    end

    // Stalled command port: command held, extra requests ignored.
    do_reset();
    rd_req = 1; rd_addr = 21'h12345;
    tick();
    check("stall_gnt", 32'(rd_gnt), 32'd1);
    stall_addr = 21'h12345;
    rd_req = 1; wr_req = 1; wr_addr = 21'h00777;
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("stall_cyc%0d", c),
            {7'd0, rd_gnt, wr_gnt, mem_cmd_valid, mem_cmd_we, busy, mem_cmd_addr},
            {7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, stall_addr});
    end
    rd_req = 0; wr_req = 0; mem_cmd_ready = 1;
    tick();
    check("stall_release_valid", 32'(mem_cmd_valid), 32'd0);
    mem_cmd_ready = 0;

    // Reset while waiting for mem_done.
    tick();
    check("wd_busy_before_reset", 32'(busy), 32'd1);
    reset = 1;
    #1;
    check("wd_reset_busy", 32'(busy), 32'd0);
    check("wd_reset_outputs", {29'd0, mem_cmd_valid, rd_done, wr_done}, 32'd0);
    #3;
    reset = 0;
    mem_done = 1;
    tick();
    mem_done = 0;
    check("late_done_ignored", {29'd0, rd_done, wr_done, busy}, 32'd0);
    rd_req = 1; rd_addr = 21'h0FACE;
    tick();
    rd_req = 0;
    check("post_reset_gnt", {10'd0, rd_gnt, mem_cmd_addr}, {10'd0, 1'b1, 21'h0FACE});

    // Re-request during rd_done: granted on the following edge.
    mem_cmd_ready = 1;
    tick();
    mem_cmd_ready = 0; mem_done = 1;
    tick();
    mem_done = 0;
    check("rerq_done", 32'(rd_done), 32'd1);
    check("rerq_no_early_gnt", 32'(rd_gnt), 32'd0);
    rd_req = 1; rd_addr = 21'h00042;
    tick();
    rd_req = 0;
    check("rerq_gnt", {10'd0, rd_gnt, mem_cmd_addr}, {10'd0, 1'b1, 21'h00042});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
